// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending machine controller.
// State encoding, coin values and the price table.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CREDIT = 3'd1,
    S_VEND   = 3'd2,
    S_REJECT = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  localparam int NICKEL_VAL = 1;
  localparam int DIME_VAL   = 2;
  localparam int PRICE_W    = 4;

  // Price in nickels; 0 marks an invalid code (0x0-0x3).
  function automatic logic [PRICE_W-1:0] price_of(input logic [3:0] code);
    if (code[3:2] == 2'b00) return '0;
    return {1'b0, code[1:0], 1'b0} + 4'd2;
  endfunction

endpackage

// File: rtl/vend_price_lookup.sv
// Combinational price lookup, shared between the controller and the display block.
module vend_price_lookup
  import vend_pkg::*;
(
  input  logic [3:0]         sel_code,
  output logic               valid,
  output logic [PRICE_W-1:0] price
);

  assign price = price_of(sel_code);
  assign valid = (price != '0);

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencing controller: credit balance, selection, vend/reject/refund.
// Optional feature macro: VEND_DIME_CHANGE_EN (refund pays dimes where possible).
module vend_controller
  import vend_pkg::*;
#(
  parameter int BAL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_nickel,
  input  logic             coin_dime,
  input  logic             sel_valid,
  input  logic [3:0]       sel_code,
  input  logic             cancel,
  output logic             dispense,
  output logic [3:0]       dispense_item,
  output logic             reject,
  output logic             coin_return,
  output logic             change_nickel,
  output logic             change_dime,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       state
);

  state_t             state_q, state_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [3:0]         vend_code_q, vend_code_d;
  logic [PRICE_W-1:0] vend_price_q, vend_price_d;
  logic [3:0]         dispense_item_q, dispense_item_d;
  logic               dispense_q, dispense_d;
  logic               reject_q, reject_d;
  logic               coin_return_q, coin_return_d;
  logic               change_nickel_q, change_nickel_d;
`ifdef VEND_DIME_CHANGE_EN
  logic               change_dime_q, change_dime_d;
`endif

  logic               lk_valid;
  logic [PRICE_W-1:0] lk_price;
  logic [1:0]         coin_amt;
  logic [BAL_W:0]     bal_sum;
  logic               coin_any, overflow, credit_cycle;

  vend_price_lookup u_price (
    .sel_code (sel_code),
    .valid    (lk_valid),
    .price    (lk_price)
  );

  assign coin_amt     = (coin_nickel ? 2'(NICKEL_VAL) : 2'd0) + (coin_dime ? 2'(DIME_VAL) : 2'd0);
  assign coin_any     = coin_nickel | coin_dime;
  assign bal_sum      = {1'b0, balance_q} + (BAL_W+1)'(coin_amt);
  assign overflow     = bal_sum[BAL_W];
  assign credit_cycle = ((state_q == S_IDLE) || (state_q == S_CREDIT)) && !sel_valid && !cancel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d         = state_q;
    balance_d       = balance_q;
    vend_code_d     = vend_code_q;
    vend_price_d    = vend_price_q;
    dispense_item_d = dispense_item_q;
    dispense_d      = 1'b0;
    reject_d        = 1'b0;
    coin_return_d   = 1'b0;
    change_nickel_d = 1'b0;
`ifdef VEND_DIME_CHANGE_EN
    change_dime_d   = 1'b0;
`endif

    // Coins are either credited whole or bounced whole.
    if (coin_any) begin
      if (credit_cycle && !overflow) balance_d = bal_sum[BAL_W-1:0];
      else                           coin_return_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sel_valid)                                state_d = S_REJECT;
        else if (coin_any && credit_cycle && !overflow) state_d = S_CREDIT;
      end
      S_CREDIT: begin
        if (cancel) begin
          state_d = S_REFUND;
        end else if (sel_valid) begin
          if (lk_valid && (balance_q >= BAL_W'(lk_price))) begin
            state_d      = S_VEND;
            vend_code_d  = sel_code;
            vend_price_d = lk_price;
          end else begin
            state_d = S_REJECT;
          end
        end
      end
      S_VEND: begin
        dispense_d      = 1'b1;
        dispense_item_d = vend_code_q;
        balance_d       = balance_q - BAL_W'(vend_price_q);
        state_d         = (balance_d != '0) ? S_REFUND : S_IDLE;
      end
      S_REJECT: begin
        reject_d = 1'b1;
        state_d  = (balance_q != '0) ? S_CREDIT : S_IDLE;
      end
      S_REFUND: begin
`ifdef VEND_DIME_CHANGE_EN
        if (balance_q >= BAL_W'(DIME_VAL)) begin
          change_dime_d = 1'b1;
          balance_d     = balance_q - BAL_W'(DIME_VAL);
        end else begin
          change_nickel_d = 1'b1;
          balance_d       = balance_q - BAL_W'(NICKEL_VAL);
        end
`else
        change_nickel_d = 1'b1;
        balance_d       = balance_q - BAL_W'(NICKEL_VAL);
`endif
        state_d = (balance_d == '0) ? S_IDLE : S_REFUND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      balance_q       <= '0;
      vend_code_q     <= '0;
      vend_price_q    <= '0;
      dispense_item_q <= '0;
      dispense_q      <= 1'b0;
      reject_q        <= 1'b0;
      coin_return_q   <= 1'b0;
      change_nickel_q <= 1'b0;
`ifdef VEND_DIME_CHANGE_EN
      change_dime_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q         <= state_d;
      balance_q       <= balance_d;
      vend_code_q     <= vend_code_d;
      vend_price_q    <= vend_price_d;
      dispense_item_q <= dispense_item_d;
      dispense_q      <= dispense_d;
      reject_q        <= reject_d;
      coin_return_q   <= coin_return_d;
      change_nickel_q <= change_nickel_d;
`ifdef VEND_DIME_CHANGE_EN
      change_dime_q   <= change_dime_d;
`endif
    end
  end

  assign state         = state_q;
  assign balance       = balance_q;
  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign reject        = reject_q;
  assign coin_return   = coin_return_q;
  assign change_nickel = change_nickel_q;
`ifdef VEND_DIME_CHANGE_EN
  assign change_dime   = change_dime_q;
`else
  assign change_dime   = 1'b0;
`endif

  // Balance can never go negative: vend needs enough credit, refund needs a coin left.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == S_VEND) |-> (balance_q >= BAL_W'(vend_price_q)));
  assert property (@(posedge clk) disable iff (rst)
    (state_q == S_REFUND) |-> (balance_q != '0));

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: vector table plus hand-written corner sequences.
module tb_vend_controller;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_nickel = 1'b0, coin_dime = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
  logic [3:0] sel_code = 4'h0;
  logic       dispense, reject, coin_return, change_nickel, change_dime;
  logic [3:0] dispense_item;
  logic [4:0] balance;
  logic [2:0] state;

  vend_controller #(.BAL_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .coin_nickel   (coin_nickel),
    .coin_dime     (coin_dime),
    .sel_valid     (sel_valid),
    .sel_code      (sel_code),
    .cancel        (cancel),
    .dispense      (dispense),
    .dispense_item (dispense_item),
    .reject        (reject),
    .coin_return   (coin_return),
    .change_nickel (change_nickel),
    .change_dime   (change_dime),
    .balance       (balance),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       n, d, s;
    logic [3:0] code;
    logic       c;
    logic       disp;
    logic [3:0] item;
    logic       rej, cret, chn;
    logic [4:0] bal;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic n, d, s, input logic [3:0] code, input logic c,
                              input logic disp, input logic [3:0] item,
                              input logic rej, cret, chn, input logic [4:0] bal, input state_t st);
    vec_t v;
    v.n = n; v.d = d; v.s = s; v.code = code; v.c = c;
    v.disp = disp; v.item = item; v.rej = rej; v.cret = cret; v.chn = chn;
    v.bal = bal; v.st = st;
    return v;
  endfunction

  // Called at a negedge: apply inputs, let one edge pass, return at the next negedge.
  task automatic cyc(input logic n, d, s, input logic [3:0] code, input logic c);
    coin_nickel = n; coin_dime = d; sel_valid = s; sel_code = code; cancel = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".dispense"},    32'(dispense),      32'(v.disp));
    check({tag, ".item"},        32'(dispense_item), 32'(v.item));
    check({tag, ".reject"},      32'(reject),        32'(v.rej));
    check({tag, ".coin_return"}, 32'(coin_return),   32'(v.cret));
    check({tag, ".chg_nickel"},  32'(change_nickel), 32'(v.chn));
    check({tag, ".chg_dime"},    32'(change_dime),   32'd0);
    check({tag, ".balance"},     32'(balance),       32'(v.bal));
    check({tag, ".state"},       32'(state),         32'(v.st));
  endtask

  initial begin
    int cnt;
    int budget;
    vec_t v;

    // two dimes, select 0x5 (price 4): exact-price vend, no change
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'h0,0,0,0, 5'd2, S_CREDIT));
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'h0,0,0,0, 5'd4, S_CREDIT));
    vecs.push_back(mk(0,0,1,4'h5,0, 0,4'h0,0,0,0, 5'd4, S_VEND));
    vecs.push_back(mk(0,0,0,4'h0,0, 1,4'h5,0,0,0, 5'd0, S_IDLE));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'h5,0,0,0, 5'd0, S_IDLE));
    // dime+nickel, select 0x6 (price 6): reject; nickel during REJECT bounced
    vecs.push_back(mk(1,1,0,4'h0,0, 0,4'h5,0,0,0, 5'd3, S_CREDIT));
    vecs.push_back(mk(0,0,1,4'h6,0, 0,4'h5,0,0,0, 5'd3, S_REJECT));
    vecs.push_back(mk(1,0,0,4'h0,0, 0,4'h5,1,1,0, 5'd3, S_CREDIT));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'h5,0,0,0, 5'd3, S_CREDIT));
    // cancel with 3 nickels: three change pulses
    vecs.push_back(mk(0,0,0,4'h0,1, 0,4'h5,0,0,0, 5'd3, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'h5,0,0,1, 5'd2, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'h5,0,0,1, 5'd1, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'h5,0,0,1, 5'd0, S_IDLE));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'h5,0,0,0, 5'd0, S_IDLE));
    // four dimes, select 0xC (price 2): dispense then 6 change nickels
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'h5,0,0,0, 5'd2, S_CREDIT));
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'h5,0,0,0, 5'd4, S_CREDIT));
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'h5,0,0,0, 5'd6, S_CREDIT));
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'h5,0,0,0, 5'd8, S_CREDIT));
    vecs.push_back(mk(0,0,1,4'hC,0, 0,4'h5,0,0,0, 5'd8, S_VEND));
    vecs.push_back(mk(0,0,0,4'h0,0, 1,4'hC,0,0,0, 5'd6, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd5, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd4, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd3, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd2, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd1, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd0, S_IDLE));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,0, 5'd0, S_IDLE));
    // balance 2, nickel together with cancel: nickel bounced, 2 nickels refunded
    vecs.push_back(mk(0,1,0,4'h0,0, 0,4'hC,0,0,0, 5'd2, S_CREDIT));
    vecs.push_back(mk(1,0,0,4'h0,1, 0,4'hC,0,1,0, 5'd2, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd1, S_REFUND));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,1, 5'd0, S_IDLE));
    // selection with zero credit rejects; coin during REJECT bounced
    vecs.push_back(mk(0,0,1,4'h5,0, 0,4'hC,0,0,0, 5'd0, S_REJECT));
    vecs.push_back(mk(1,0,0,4'h0,0, 0,4'hC,1,1,0, 5'd0, S_IDLE));
    vecs.push_back(mk(0,0,0,4'h0,0, 0,4'hC,0,0,0, 5'd0, S_IDLE));

    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v = mk(0,0,0,4'h0,0, 0,4'h0,0,0,0, 5'd0, S_IDLE);
    check_all("reset", v);

    foreach (vecs[i]) begin
      cyc(vecs[i].n, vecs[i].d, vecs[i].s, vecs[i].code, vecs[i].c);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // build to 30, overflow dime bounced, invalid code rejected, fill to 31, drain
    for (int i = 0; i < 15; i++) cyc(0,1,0,4'h0,0);
    check("bal30.balance", 32'(balance), 32'd30);
    cyc(0,1,0,4'h0,0);
    check("ovf.coin_return", 32'(coin_return), 32'd1);
    check("ovf.balance",     32'(balance),     32'd30);
    cyc(0,0,1,4'h2,0);
    check("inv.state", 32'(state), 32'(S_REJECT));
    cyc(0,0,0,4'h0,0);
    check("inv.reject",  32'(reject),  32'd1);
    check("inv.state2",  32'(state),   32'(S_CREDIT));
    check("inv.balance", 32'(balance), 32'd30);
    cyc(1,0,0,4'h0,0);
    check("max.balance",     32'(balance),     32'd31);
    check("max.coin_return", 32'(coin_return), 32'd0);
    cyc(1,0,0,4'h0,0);
    check("max_ovf.coin_return", 32'(coin_return), 32'd1);
    check("max_ovf.balance",     32'(balance),     32'd31);
    cyc(0,0,0,4'h0,1);
    check("drain.state", 32'(state), 32'(S_REFUND));
    cnt = 0;
    budget = 0;
    while (state != 3'(S_IDLE) && budget < 40) begin
      cyc(0,0,0,4'h0,0);
      if (change_nickel) cnt++;
      budget++;
    end
    check("drain.timeout", 32'(budget < 40), 32'd1);
    check("drain.pulses",  32'(cnt),         32'd31);
    check("drain.balance", 32'(balance),     32'd0);

    // reset asserted mid-refund with balance 5
    cyc(0,1,0,4'h0,0);
    cyc(0,1,0,4'h0,0);
    cyc(1,0,0,4'h0,0);
    cyc(0,0,0,4'h0,1);
    check("rstref.pre_state",   32'(state),   32'(S_REFUND));
    check("rstref.pre_balance", 32'(balance), 32'd5);
    rst = 1'b1;
    #1;
    check("rstref.balance", 32'(balance),       32'd0);
    check("rstref.state",   32'(state),         32'(S_IDLE));
    check("rstref.chn",     32'(change_nickel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0,4'h0,0);
      if (change_nickel) cnt++;
    end
    check("rstref.no_payout", 32'(cnt),     32'd0);
    check("rstref.idle",      32'(state),   32'(S_IDLE));
    check("rstref.bal_after", 32'(balance), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
